// File: rtl/minmax_decimator.sv
// Multi-channel window decimator ahead of SRAM write: per window of 2^k samples it
// emits the first sample, the boxcar average, or a min word followed by a max word.
module minmax_decimator #(
  parameter int DW       = 8,
  parameter int CH       = 2,
  parameter int MAX_LOG2 = 10
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             IN_VALID,
  input  logic [CH*DW-1:0] DATA_IN,
  input  logic [1:0]       MODE,
  input  logic [3:0]       DECIM_LOG2,
  input  logic             RESTART,
  output logic [CH*DW-1:0] OUT_DATA,
  output logic             OUT_VALID,
  output logic             OUT_IS_MAX,
  output logic             WIN_START
);

  localparam int AW = DW + MAX_LOG2;
  localparam int CW = MAX_LOG2;
  localparam logic [3:0] MAX_K = 4'(MAX_LOG2);

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'b00,
    MODE_PEAK   = 2'b01,
    MODE_AVG    = 2'b10
  } mode_e;

  mode_e             mode_q, mode_d, mode_in, mode_cur;
  logic [3:0]        k_q, k_d, k_in, k_cur;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_cur, last_idx;
  logic [CH*DW-1:0]  min_q, min_d, max_q, max_d, first_q, first_d;
  logic [CH*AW-1:0]  acc_q, acc_d;
  logic              pend_q, pend_d;
  logic [CH*DW-1:0]  pend_max_q, pend_max_d;
  logic [CH*DW-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_is_max_q, out_is_max_d;
  logic              win_start_q, win_start_d;

  logic              is_first, is_last;
  logic [CH*DW-1:0]  min_nx, max_nx, first_nx, avg_nx;
  logic [CH*AW-1:0]  acc_nx;

  always_comb begin
    mode_d       = mode_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    min_d        = min_q;
    max_d        = max_q;
    first_d      = first_q;
    acc_d        = acc_q;
    pend_d       = 1'b0;
    pend_max_d   = pend_max_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    out_is_max_d = 1'b0;
    win_start_d  = 1'b0;

    // Configuration is only sampled on a window's first sample; reserved mode maps to sample.
    is_first = RESTART || (cnt_q == '0);
    k_in     = (DECIM_LOG2 > MAX_K) ? MAX_K : DECIM_LOG2;
    mode_in  = (MODE == 2'b11) ? MODE_SAMPLE : mode_e'(MODE);
    if (mode_in == MODE_PEAK && k_in == 4'd0) k_in = 4'd1;
    mode_cur = is_first ? mode_in : mode_q;
    k_cur    = is_first ? k_in : k_q;
    cnt_cur  = is_first ? '0 : cnt_q;
    last_idx = CW'((32'd1 << k_cur) - 32'd1);
    is_last  = (cnt_cur == last_idx);

    for (int n = 0; n < CH; n++) begin
      if (is_first) begin
        min_nx[n*DW +: DW]   = DATA_IN[n*DW +: DW];
        max_nx[n*DW +: DW]   = DATA_IN[n*DW +: DW];
        first_nx[n*DW +: DW] = DATA_IN[n*DW +: DW];
        acc_nx[n*AW +: AW]   = AW'(DATA_IN[n*DW +: DW]);
      end else begin
        min_nx[n*DW +: DW]   = (DATA_IN[n*DW +: DW] < min_q[n*DW +: DW]) ?
                               DATA_IN[n*DW +: DW] : min_q[n*DW +: DW];
        max_nx[n*DW +: DW]   = (DATA_IN[n*DW +: DW] > max_q[n*DW +: DW]) ?
                               DATA_IN[n*DW +: DW] : max_q[n*DW +: DW];
        first_nx[n*DW +: DW] = first_q[n*DW +: DW];
        acc_nx[n*AW +: AW]   = acc_q[n*AW +: AW] + AW'(DATA_IN[n*DW +: DW]);
      end
      avg_nx[n*DW +: DW] = DW'(acc_nx[n*AW +: AW] >> k_cur);
    end

    if (IN_VALID) begin
      mode_d      = mode_cur;
      k_d         = k_cur;
      cnt_d       = is_last ? '0 : cnt_cur + CW'(1);
      min_d       = min_nx;
      max_d       = max_nx;
      first_d     = first_nx;
      acc_d       = acc_nx;
      win_start_d = is_first;
      if (is_last) begin
        out_valid_d = 1'b1;
        case (mode_cur)
          MODE_PEAK: begin
            out_data_d = min_nx;
            pend_d     = 1'b1;
            pend_max_d = max_nx;
          end
          MODE_AVG: out_data_d = avg_nx;
          default:  out_data_d = first_nx;
        endcase
      end
    end else if (RESTART) begin
      cnt_d = '0;
    end

    // An issued max word always goes out; it only collides with a new result after a
    // mid-stream switch to a 1-sample window, where the max word takes the slot.
    if (pend_q) begin
      out_data_d   = pend_max_q;
      out_is_max_d = 1'b1;
      out_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      mode_q       <= MODE_SAMPLE;
      k_q          <= '0;
      cnt_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      first_q      <= '0;
      acc_q        <= '0;
      pend_q       <= 1'b0;
      pend_max_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_is_max_q <= 1'b0;
      win_start_q  <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      first_q      <= first_d;
      acc_q        <= acc_d;
      pend_q       <= pend_d;
      pend_max_q   <= pend_max_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_is_max_q <= out_is_max_d;
      win_start_q  <= win_start_d;
    end
  end

  assign OUT_DATA   = out_data_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_IS_MAX = out_is_max_q;
  assign WIN_START  = win_start_q;

endmodule

// File: tb/tb_minmax_decimator.sv
// Directed bench for minmax_decimator: expected words are queued as stimulus is driven
// and popped by a monitor whenever OUT_VALID is seen.
module tb_minmax_decimator;

  localparam int DW = 8;
  localparam int CH = 2;
  localparam int W  = CH*DW + 1;

  logic             clk = 1'b0;
  logic             clr;
  logic             in_valid;
  logic [CH*DW-1:0] data_in;
  logic [1:0]       mode;
  logic [3:0]       decim_log2;
  logic             restart;
  logic [CH*DW-1:0] out_data;
  logic             out_valid;
  logic             out_is_max;
  logic             win_start;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  minmax_decimator #(.DW(DW), .CH(CH), .MAX_LOG2(10)) dut (
    .CLK(clk), .CLR(clr), .IN_VALID(in_valid), .DATA_IN(data_in), .MODE(mode),
    .DECIM_LOG2(decim_log2), .RESTART(restart), .OUT_DATA(out_data),
    .OUT_VALID(out_valid), .OUT_IS_MAX(out_is_max), .WIN_START(win_start)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL out_word unexpected got=%h exp=none", {out_is_max, out_data});
      end
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({out_is_max, out_data} === e) else begin
          errors++;
          $error("FAIL out_word got=%h exp=%h", {out_is_max, out_data}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic push(input logic is_max, input logic [7:0] c0, input logic [7:0] c1);
    exp_q.push_back({is_max, c1, c0});
  endtask

  task automatic send(input logic [7:0] c0, input logic [7:0] c1, input logic rs,
                      input logic first);
    in_valid = 1'b1;
    data_in  = {c1, c0};
    restart  = rs;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    restart  = 1'b0;
    checks++;
    assert (win_start === first) else begin
      errors++;
      $error("FAIL win_start got=%0b exp=%0b", win_start, first);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({out_data, out_valid, out_is_max, win_start} === '0) else begin
      errors++;
      $error("FAIL %s got=%h/%b/%b/%b exp=0", tag, out_data, out_valid, out_is_max, win_start);
    end
  endtask

  task automatic clr_pulse(input logic [15:0] junk);
    clr      = 1'b1;
    in_valid = 1'b1;
    data_in  = junk;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] a, b;
    int s0, s1;
    clr = 1'b1; in_valid = 1'b0; data_in = '0; mode = 2'b00; decim_log2 = 4'd0;
    restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    check_zero("reset_outputs");

    // sample mode, k=2
    mode = 2'b00; decim_log2 = 4'd2;
    push(1'b0, 8'd10, 8'd5);
    send(8'd10, 8'd5, 1'b0, 1'b1);
    send(8'd20, 8'd6, 1'b0, 1'b0);
    send(8'd30, 8'd7, 1'b0, 1'b0);
    send(8'd40, 8'd8, 1'b0, 1'b0);
    idle(2);

    // peak mode, k=2, two back-to-back windows
    mode = 2'b01;
    push(1'b0, 8'd3, 8'd1);
    push(1'b1, 8'd200, 8'd4);
    send(8'd50, 8'd1, 1'b0, 1'b1);
    send(8'd3, 8'd2, 1'b0, 1'b0);
    send(8'd200, 8'd3, 1'b0, 1'b0);
    send(8'd7, 8'd4, 1'b0, 1'b0);
    push(1'b0, 8'd9, 8'd9);
    push(1'b1, 8'd9, 8'd9);
    for (int i = 0; i < 4; i++) send(8'd9, 8'd9, 1'b0, i == 0);
    idle(2);

    // average mode, k=3
    mode = 2'b10; decim_log2 = 4'd3;
    push(1'b0, 8'd255, 8'd0);
    for (int i = 0; i < 8; i++) send(8'd255, 8'd0, 1'b0, i == 0);
    push(1'b0, 8'd4, 8'd45);
    for (int i = 1; i <= 8; i++) send(8'(i), 8'(10*i), 1'b0, i == 1);
    idle(2);

    // peak mode with k=0 behaves as k=1
    mode = 2'b01; decim_log2 = 4'd0;
    push(1'b0, 8'd5, 8'd2);
    push(1'b1, 8'd7, 8'd9);
    send(8'd5, 8'd9, 1'b0, 1'b1);
    send(8'd7, 8'd2, 1'b0, 1'b0);
    push(1'b0, 8'd0, 8'd100);
    push(1'b1, 8'd100, 8'd255);
    send(8'd100, 8'd100, 1'b0, 1'b1);
    send(8'd0, 8'd255, 1'b0, 1'b0);
    idle(2);

    // clamp to 1024 samples, config changed mid-window
    mode = 2'b10; decim_log2 = 4'd15;
    s0 = 0; s1 = 0;
    for (int i = 0; i < 1024; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      s0 += a;
      s1 += b;
      if (i == 1023) push(1'b0, 8'(s0 >> 10), 8'(s1 >> 10));
      send(a, b, 1'b0, i == 0);
      if (i == 0) begin
        mode = 2'b00; decim_log2 = 4'd1;
      end
    end
    push(1'b0, 8'd11, 8'd12);
    send(8'd11, 8'd12, 1'b0, 1'b1);
    send(8'd13, 8'd14, 1'b0, 1'b0);
    idle(2);

    // RESTART with a sample after 2 of 4
    mode = 2'b00; decim_log2 = 4'd2;
    push(1'b0, 8'd99, 8'd77);
    send(8'd1, 8'd2, 1'b0, 1'b1);
    send(8'd3, 8'd4, 1'b0, 1'b0);
    send(8'd99, 8'd77, 1'b1, 1'b1);
    send(8'd5, 8'd6, 1'b0, 1'b0);
    send(8'd7, 8'd8, 1'b0, 1'b0);
    send(8'd9, 8'd10, 1'b0, 1'b0);
    idle(2);

    // RESTART on the min-word cycle keeps the max word
    mode = 2'b01; decim_log2 = 4'd1;
    push(1'b0, 8'd10, 8'd30);
    push(1'b1, 8'd20, 8'd40);
    send(8'd20, 8'd30, 1'b0, 1'b1);
    send(8'd10, 8'd40, 1'b0, 1'b0);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    push(1'b0, 8'd1, 8'd2);
    push(1'b1, 8'd3, 8'd4);
    send(8'd1, 8'd2, 1'b0, 1'b1);
    send(8'd3, 8'd4, 1'b0, 1'b0);
    idle(2);

    // reset with a max word pending, then reset mid-window
    decim_log2 = 4'd2;
    push(1'b0, 8'd20, 8'd1);
    send(8'd60, 8'd1, 1'b0, 1'b1);
    send(8'd80, 8'd2, 1'b0, 1'b0);
    send(8'd20, 8'd3, 1'b0, 1'b0);
    send(8'd40, 8'd4, 1'b0, 1'b0);
    clr_pulse(16'hABCD);
    check_zero("clr_pending");
    idle(2);
    send(8'd5, 8'd5, 1'b0, 1'b1);
    send(8'd6, 8'd6, 1'b0, 1'b0);
    clr_pulse(16'h1234);
    check_zero("clr_midwin");
    push(1'b0, 8'd2, 8'd3);
    push(1'b1, 8'd200, 8'd100);
    send(8'd100, 8'd3, 1'b0, 1'b1);
    send(8'd2, 8'd100, 1'b0, 1'b0);
    send(8'd200, 8'd50, 1'b0, 1'b0);
    send(8'd50, 8'd10, 1'b0, 1'b0);
    idle(5);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL words_missing got=%0d exp=0", exp_q.size());
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
